// File: rtl/mipi_rffe_master_pkg.sv
// Shared constants, command encodings and FSM state type for the RFFE master.
package mipi_rffe_master_pkg;

    localparam logic [1:0] MIPI_CMD_REGWR  = 2'd0;
    localparam logic [1:0] MIPI_CMD_REGRD  = 2'd1;
    localparam logic [1:0] MIPI_CMD_REG0WR = 2'd2;
    localparam logic [1:0] MIPI_CMD_RSVD   = 2'd3;

    localparam int MIPI_SA_NBIT       = 4;
    localparam int MIPI_ADDR_NBIT     = 5;
    localparam int MIPI_FRM_CMD_NBIT  = 13;
    localparam int MIPI_FRM_DATA_NBIT = 9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SSC1,
        ST_SSC0,
        ST_CMD,
        ST_DATA_W,
        ST_BP_R,
        ST_DATA_R,
        ST_BP,
        ST_RSP
    } state_t;

endpackage

// File: rtl/mipi_rffe_master_bit_timer.sv
// Bit-cell divider: flags each bit boundary and the mid-bit SCLK fall, and owns the SCLK register.
module mipi_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic sclk_en,
    output logic bit_start,
    output logic sclk_fall,
    output logic sclk
);

    localparam int CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] FALL = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    // bit_start marks the edge on which the next bit cell begins
    assign bit_start = !clr && (cnt_reg == LAST);
    assign sclk_fall = !clr && (cnt_reg == FALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            sclk    <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            sclk    <= 1'b0;
        end else if (bit_start) begin
            cnt_reg <= '0;
            sclk    <= sclk_en;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (sclk_fall)
                sclk <= 1'b0;
        end
    end

endmodule

// File: rtl/mipi_rffe_master.sv
// RFFE master: serialises SSC, command frame, data frame and bus park; returns read data and parity status.
module mipi_rffe_master
    import mipi_rffe_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_vd,
    output logic       cmd_rdy,
    input  logic [1:0] cmd_type,
    input  logic [3:0] cmd_sa,
    input  logic [4:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_vd,
    output logic [7:0] rsp_rdata,
    output logic       rsp_perr,
    output logic       sclk,
    output logic       sdo,
    output logic       sdo_en,
    input  logic       sdi
);

    function automatic logic odd_par(input logic [11:0] v);
        return ~^v;
    endfunction

    state_t                          state_reg;
    logic [MIPI_FRM_CMD_NBIT-1:0]    sh_reg;
    logic [MIPI_FRM_DATA_NBIT-1:0]   wd_reg;
    logic [MIPI_FRM_DATA_NBIT-1:0]   rx_reg;
    logic [3:0]                      bcnt_reg;
    logic [1:0]                      type_reg;

    logic [7:0]                      cmd_byte;
    logic [MIPI_FRM_CMD_NBIT-1:0]    cmd_frame;
    logic [MIPI_FRM_DATA_NBIT-1:0]   data_frame;
    logic                            bit_start;
    logic                            sclk_fall;
    logic                            timer_clr;
    logic                            sclk_en;

    always_comb begin
        cmd_byte = 8'h00;
        case (cmd_type)
            MIPI_CMD_REGWR:  cmd_byte = {3'b010, cmd_addr};
            MIPI_CMD_REGRD:  cmd_byte = {3'b011, cmd_addr};
            MIPI_CMD_REG0WR: cmd_byte = {1'b1, cmd_wdata[6:0]};
            default:         cmd_byte = 8'h00;
        endcase
    end

    assign cmd_frame  = {cmd_sa, cmd_byte, odd_par({cmd_sa, cmd_byte})};
    assign data_frame = {cmd_wdata, odd_par({4'd0, cmd_wdata})};

    // SCLK pulses in every bit cell that follows SSC, up to and including bus park
    assign timer_clr = (state_reg == ST_IDLE) || (state_reg == ST_RSP);
    assign sclk_en   = (state_reg == ST_SSC0) || (state_reg == ST_CMD) || (state_reg == ST_DATA_W)
                    || (state_reg == ST_BP_R) || (state_reg == ST_DATA_R);

    mipi_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (timer_clr),
        .sclk_en   (sclk_en),
        .bit_start (bit_start),
        .sclk_fall (sclk_fall),
        .sclk      (sclk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sh_reg    <= '0;
            wd_reg    <= '0;
            rx_reg    <= '0;
            bcnt_reg  <= '0;
            type_reg  <= '0;
            cmd_rdy   <= 1'b1;
            sdo       <= 1'b0;
            sdo_en    <= 1'b1;
            rsp_vd    <= 1'b0;
            rsp_rdata <= '0;
            rsp_perr  <= 1'b0;
        end else begin
            rsp_vd <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_vd && cmd_rdy) begin
                        cmd_rdy  <= 1'b0;
                        type_reg <= cmd_type;
                        sh_reg   <= cmd_frame;
                        wd_reg   <= data_frame;
                        if (cmd_type == MIPI_CMD_RSVD) begin
                            state_reg <= ST_RSP;
                            rsp_vd    <= 1'b1;
                            rsp_rdata <= 8'h00;
                            rsp_perr  <= 1'b1;
                        end else begin
                            state_reg <= ST_SSC1;
                            sdo       <= 1'b1;
                        end
                    end
                end
                ST_SSC1: if (bit_start) begin
                    state_reg <= ST_SSC0;
                    sdo       <= 1'b0;
                end
                ST_SSC0: if (bit_start) begin
                    state_reg <= ST_CMD;
                    sdo       <= sh_reg[12];
                    sh_reg    <= {sh_reg[11:0], 1'b0};
                    bcnt_reg  <= '0;
                end
                ST_CMD: if (bit_start) begin
                    if (bcnt_reg == 4'd12) begin
                        bcnt_reg <= '0;
                        case (type_reg)
                            MIPI_CMD_REGWR: begin
                                state_reg <= ST_DATA_W;
                                sdo       <= wd_reg[8];
                                wd_reg    <= {wd_reg[7:0], 1'b0};
                            end
                            MIPI_CMD_REGRD: begin
                                state_reg <= ST_BP_R;
                                sdo       <= 1'b0;
                            end
                            default: begin
                                state_reg <= ST_BP;
                                sdo       <= 1'b0;
                            end
                        endcase
                    end else begin
                        sdo      <= sh_reg[12];
                        sh_reg   <= {sh_reg[11:0], 1'b0};
                        bcnt_reg <= bcnt_reg + 4'd1;
                    end
                end
                ST_DATA_W: if (bit_start) begin
                    if (bcnt_reg == 4'd8) begin
                        state_reg <= ST_BP;
                        sdo       <= 1'b0;
                    end else begin
                        sdo      <= wd_reg[8];
                        wd_reg   <= {wd_reg[7:0], 1'b0};
                        bcnt_reg <= bcnt_reg + 4'd1;
                    end
                end
                ST_BP_R: begin
                    // release the line for the slave once SCLK has fallen
                    if (sclk_fall)
                        sdo_en <= 1'b0;
                    if (bit_start) begin
                        state_reg <= ST_DATA_R;
                        bcnt_reg  <= '0;
                    end
                end
                ST_DATA_R: begin
                    if (sclk_fall)
                        rx_reg <= {rx_reg[7:0], sdi};
                    if (bit_start) begin
                        if (bcnt_reg == 4'd8)
                            state_reg <= ST_BP;
                        else
                            bcnt_reg <= bcnt_reg + 4'd1;
                    end
                end
                ST_BP: if (bit_start) begin
                    state_reg <= ST_RSP;
                    sdo       <= 1'b0;
                    sdo_en    <= 1'b1;
                    rsp_vd    <= 1'b1;
                    if (type_reg == MIPI_CMD_REGRD) begin
                        rsp_rdata <= rx_reg[8:1];
                        rsp_perr  <= (odd_par({4'd0, rx_reg[8:1]}) != rx_reg[0]);
                    end else begin
                        rsp_rdata <= 8'h00;
                        rsp_perr  <= 1'b0;
                    end
                end
                ST_RSP: begin
                    state_reg <= ST_IDLE;
                    cmd_rdy   <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mipi_rffe_master.sv
// Scoreboard bench for mipi_rffe_master: frame bits, response timing, read parity, busy/back-to-back and reset.
module tb_mipi_rffe_master;

    localparam int CLK_DIV = 2;
    localparam int T       = 2 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_vd = 1'b0;
    logic       cmd_rdy;
    logic [1:0] cmd_type = 2'd0;
    logic [3:0] cmd_sa = 4'd0;
    logic [4:0] cmd_addr = 5'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_vd;
    logic [7:0] rsp_rdata;
    logic       rsp_perr;
    logic       sclk;
    logic       sdo;
    logic       sdo_en;
    logic       sdi = 1'b0;

    mipi_rffe_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_vd    (cmd_vd),
        .cmd_rdy   (cmd_rdy),
        .cmd_type  (cmd_type),
        .cmd_sa    (cmd_sa),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_vd    (rsp_vd),
        .rsp_rdata (rsp_rdata),
        .rsp_perr  (rsp_perr),
        .sclk      (sclk),
        .sdo       (sdo),
        .sdo_en    (sdo_en),
        .sdi       (sdi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and slave: record sdo/sdo_en at each SCLK rise, drive read bits during DATA_R
    logic       sclk_q = 1'b0;
    int         nrise = 0;
    logic       cap [0:31];
    logic       en_cap [0:31];
    logic [8:0] slave_word = 9'h0;

    always @(negedge clk) begin
        sclk_q <= sclk;
        if (cmd_rdy)
            nrise <= 0;
        else if (sclk && !sclk_q && nrise < 32) begin
            cap[nrise]    <= sdo;
            en_cap[nrise] <= sdo_en;
            if (nrise >= 14 && nrise <= 22)
                sdi <= slave_word[22 - nrise];
            nrise <= nrise + 1;
        end
    end

    typedef struct {
        logic [7:0] rdata;
        logic       perr;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [1:0] t, input logic [3:0] sa, input logic [4:0] a,
                         input logic [7:0] d, input logic [7:0] er, input logic ep, input int nbits);
        @(negedge clk);
        cmd_type  = t;
        cmd_sa    = sa;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_vd    = 1'b1;
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_rdy: cmd_rdy=%b required 1", cmd_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_vd = 1'b0;
        sb.push_back('{er, ep, cyc + nbits * T});
        if (t != 2'd3) begin
            n_cmp++;
            if (sdo !== 1'b1 || sclk !== 1'b0) begin
                n_bad++;
                $display("FAIL ssc1: sdo=%b sclk=%b required sdo=1 sclk=0", sdo, sclk);
            end
        end
    endtask

    task automatic wait_rsp(input int max, input string name);
        exp_t e;
        for (int i = 0; i < max && rsp_vd !== 1'b1; i++)
            @(negedge clk);
        n_cmp++;
        if (rsp_vd !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_timeout: no rsp_vd within %0d cycles", name, max);
            if (sb.size() > 0) sb.delete(0);
            return;
        end
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s_unexpected: rsp_vd with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        n_cmp += 4;
        if (rsp_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL %s_rdata: got %h required %h", name, rsp_rdata, e.rdata);
        end
        if (rsp_perr !== e.perr) begin
            n_bad++;
            $display("FAIL %s_perr: got %b required %b", name, rsp_perr, e.perr);
        end
        if (cyc != e.due) begin
            n_bad++;
            $display("FAIL %s_latency: rsp at cycle %0d required %0d", name, cyc, e.due);
        end
        if (sdo_en !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_sdo_en: got %b required 1 in RSP", name, sdo_en);
        end
        $display("rsp %s: cycle=%0d rdata=%h perr=%b", name, cyc, rsp_rdata, rsp_perr);
    endtask

    function automatic logic [12:0] got_cmd();
        logic [12:0] v;
        for (int i = 0; i < 13; i++) v[12 - i] = cap[i];
        return v;
    endfunction

    task automatic check_frame(input string name, input logic [12:0] exp_cmd, input int exp_rise);
        logic [12:0] g;
        g = got_cmd();
        n_cmp += 2;
        if (g !== exp_cmd) begin
            n_bad++;
            $display("FAIL %s_cmd_bits: got %b required %b", name, g, exp_cmd);
        end
        if (nrise != exp_rise) begin
            n_bad++;
            $display("FAIL %s_sclk_count: got %0d required %0d", name, nrise, exp_rise);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp += 7;
        if (cmd_rdy !== 1'b1)    begin n_bad++; $display("FAIL rst_cmd_rdy: got %b required 1", cmd_rdy); end
        if (sclk !== 1'b0)       begin n_bad++; $display("FAIL rst_sclk: got %b required 0", sclk); end
        if (sdo !== 1'b0)        begin n_bad++; $display("FAIL rst_sdo: got %b required 0", sdo); end
        if (sdo_en !== 1'b1)     begin n_bad++; $display("FAIL rst_sdo_en: got %b required 1", sdo_en); end
        if (rsp_vd !== 1'b0)     begin n_bad++; $display("FAIL rst_rsp_vd: got %b required 0", rsp_vd); end
        if (rsp_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_rdata: got %h required 00", rsp_rdata); end
        if (rsp_perr !== 1'b0)   begin n_bad++; $display("FAIL rst_rsp_perr: got %b required 0", rsp_perr); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_reg_write();
        logic [8:0] g;
        issue(2'd0, 4'h5, 5'h1C, 8'hA5, 8'h00, 1'b0, 25);
        wait_rsp(200, "regwr");
        check_frame("regwr", 13'b0101_0101_1100_1, 23);
        for (int i = 0; i < 9; i++) g[8 - i] = cap[13 + i];
        n_cmp++;
        if (g !== 9'b1010_0101_1) begin
            n_bad++;
            $display("FAIL regwr_data_bits: got %b required 101001011", g);
        end
    endtask

    task automatic test_reg_read(input logic flip, input logic exp_perr, input string name);
        logic en_any;
        slave_word = {8'h3C, 1'b1 ^ flip};
        issue(2'd1, 4'hF, 5'h00, 8'h00, 8'h3C, exp_perr, 26);
        wait_rsp(200, name);
        check_frame(name, 13'b1111_0110_0000_1, 24);
        en_any = 1'b0;
        for (int i = 14; i <= 22; i++) en_any = en_any | en_cap[i];
        n_cmp += 2;
        if (en_cap[13] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_bpr_en: got %b required 1 in BP_R high half", name, en_cap[13]);
        end
        if (en_any !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_datar_en: got sdo_en=%b required 0 in DATA_R", name, en_any);
        end
    endtask

    task automatic test_reg0_write();
        issue(2'd2, 4'h1, 5'h00, 8'h7F, 8'h00, 1'b0, 16);
        wait_rsp(200, "reg0wr");
        check_frame("reg0wr", 13'b0001_1111_1111_0, 14);
    endtask

    task automatic test_reserved();
        issue(2'd3, 4'h3, 5'h04, 8'h55, 8'h00, 1'b1, 0);
        wait_rsp(10, "rsvd");
    endtask

    task automatic test_busy_pulse();
        issue(2'd0, 4'h2, 5'h03, 8'h0F, 8'h00, 1'b0, 25);
        repeat (30) @(negedge clk);
        cmd_type = 2'd3;
        cmd_vd   = 1'b1;
        n_cmp++;
        if (cmd_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_rdy: cmd_rdy=%b required 0 mid-frame", cmd_rdy);
        end
        @(negedge clk);
        cmd_vd = 1'b0;
        wait_rsp(200, "busy");
    endtask

    task automatic test_back_to_back();
        int r;
        @(negedge clk);
        cmd_type  = 2'd2;
        cmd_sa    = 4'h1;
        cmd_wdata = 8'h7F;
        cmd_vd    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{8'h00, 1'b0, cyc + 16 * T});
        wait_rsp(200, "b2b_first");
        r = cyc;
        @(negedge clk);
        n_cmp++;
        if (cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_rdy: cmd_rdy=%b required 1 one cycle after rsp", cmd_rdy);
        end
        @(negedge clk);
        cmd_vd = 1'b0;
        n_cmp++;
        if (cmd_rdy !== 1'b0 || sdo !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: cmd_rdy=%b sdo=%b required 0/1 at cycle %0d", cmd_rdy, sdo, r + 2);
        end
        sb.push_back('{8'h00, 1'b0, r + 2 + 16 * T});
        wait_rsp(200, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int extra;
        issue(2'd0, 4'h5, 5'h1C, 8'hA5, 8'h00, 1'b0, 25);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sclk !== 1'b0 || sdo !== 1'b0 || sdo_en !== 1'b1 || cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_outputs: sclk=%b sdo=%b sdo_en=%b cmd_rdy=%b required 0/0/1/1",
                     sclk, sdo, sdo_en, cmd_rdy);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (120) begin
            @(negedge clk);
            if (rsp_vd === 1'b1) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL rstmid_no_rsp: got %0d responses required 0", extra);
        end
        $display("reset mid-frame: %0d stray responses", extra);
        issue(2'd2, 4'h6, 5'h00, 8'h12, 8'h00, 1'b0, 16);
        wait_rsp(200, "post_rst");
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_reg_read(1'b0, 1'b0, "regrd");
        test_reg_read(1'b1, 1'b1, "regrd_perr");
        test_reg0_write();
        test_reserved();
        test_busy_pulse();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
